// File: rtl/capture_ring_sched.sv
// Record-slot scheduler for the capture-to-host write path: takes packet descriptors, allocates
// space in a circular host ring, issues one start command per record and tracks completion.
module capture_ring_sched #(
    parameter int unsigned HDR_BYTES      = 16,
    parameter int unsigned MAX_PKT        = 2048,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] ring_base,
    input  logic [31:0] ring_size,
    input  logic [31:0] host_rd_ptr,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [31:0] desc_begin,
    input  logic [31:0] desc_end,
    output logic        wr_ctrl,
    output logic [31:0] control,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] write_address,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] wr_ptr,
    output logic [31:0] pkt_count,
    output logic [15:0] drop_count,
    output logic        busy,
    output logic        err
);

    localparam logic [31:0] HdrBytes      = 32'(HDR_BYTES);
    localparam logic [31:0] MaxPkt        = 32'(MAX_PKT);
    localparam logic [31:0] TimeoutCycles = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StWaitSpace,
        StIssue,
        StWaitDone,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pkt_begin_q, pkt_begin_d;
    logic [31:0] pkt_end_q, pkt_end_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        err_q, err_d;
    logic [31:0] gap_q, gap_d;
    logic        wrap_q, wrap_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_ctrl_q, wr_ctrl_d;
    logic [31:0] tmo_q, tmo_d;
    logic        enable_q;

    logic [31:0] len;
    logic [31:0] rec;
    logic [31:0] room;
    logic [31:0] gap_calc;
    logic [31:0] gap_use;
    logic [31:0] occ;
    logic [31:0] free_bytes;
    logic [32:0] need;
    logic [31:0] offset;
    logic [31:0] next_ptr;
    logic        len_bad;
    logic        fits;
    logic        accept;
    logic        drop_inc;

    assign len      = pkt_end_q - pkt_begin_q;
    assign len_bad  = (len == 32'd0) || (len > MaxPkt);
    assign rec      = HdrBytes + ((len + 32'd3) & ~32'd3);
    assign room     = ring_size - wr_ptr_q;
    assign gap_calc = (room < rec) ? room : 32'd0;

    // Both pointers live in [0, ring_size), so one conditional add replaces the modulo.
    assign occ        = (wr_ptr_q >= host_rd_ptr) ? (wr_ptr_q - host_rd_ptr)
                                                  : (wr_ptr_q - host_rd_ptr + ring_size);
    assign free_bytes = ring_size - occ;
    assign gap_use    = (state_q == StCalc) ? gap_calc : gap_q;
    assign need       = {1'b0, gap_use} + {1'b0, rec};
    assign fits       = need < {1'b0, free_bytes};

    assign offset   = wrap_q ? 32'd0 : wr_ptr_q;
    assign next_ptr = offset + rec;

    assign desc_ready = (state_q == StIdle) && enable && !err_q && !reset;
    assign accept     = desc_valid && desc_ready;

    always_comb begin
        state_d      = state_q;
        pkt_begin_d  = pkt_begin_q;
        pkt_end_d    = pkt_end_q;
        wr_ptr_d     = wr_ptr_q;
        seq_d        = seq_q;
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        err_d        = err_q;
        gap_d        = gap_q;
        wrap_d       = wrap_q;
        addr_d       = addr_q;
        wr_ctrl_d    = 1'b0;
        tmo_d        = tmo_q;
        drop_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    pkt_begin_d = desc_begin;
                    pkt_end_d   = desc_end;
                    state_d     = StCalc;
                end
            end
            StCalc: begin
                if (len_bad) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end else begin
                    gap_d = gap_calc;
                    // Space check folded into CALC so an unstalled record issues at N+2.
                    if (fits) begin
                        addr_d    = ring_base + ((gap_calc != 32'd0) ? 32'd0 : wr_ptr_q);
                        wrap_d    = (gap_calc != 32'd0);
                        wr_ctrl_d = 1'b1;
                        state_d   = StIssue;
                    end else begin
                        state_d = StWaitSpace;
                    end
                end
            end
            StWaitSpace: begin
                if (fits) begin
                    addr_d    = ring_base + ((gap_q != 32'd0) ? 32'd0 : wr_ptr_q);
                    wrap_d    = (gap_q != 32'd0);
                    wr_ctrl_d = 1'b1;
                    state_d   = StIssue;
                end else if (!enable) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end
            end
            StIssue: begin
                tmo_d   = 32'd0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (wr_ctrl_rdy) begin
                    wr_ptr_d    = (next_ptr == ring_size) ? 32'd0 : next_ptr;
                    seq_d       = seq_q + 16'd1;
                    pkt_count_d = pkt_count_q + 32'd1;
                    state_d     = StIdle;
                end else if (tmo_q + 32'd1 == TimeoutCycles) begin
                    err_d   = 1'b1;
                    state_d = StError;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (drop_inc && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end

        if (enable && !enable_q) begin
            wr_ptr_d = 32'd0;
            seq_d    = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            pkt_begin_q  <= 32'd0;
            pkt_end_q    <= 32'd0;
            wr_ptr_q     <= 32'd0;
            seq_q        <= 16'd0;
            pkt_count_q  <= 32'd0;
            drop_count_q <= 16'd0;
            err_q        <= 1'b0;
            gap_q        <= 32'd0;
            wrap_q       <= 1'b0;
            addr_q       <= 32'd0;
            wr_ctrl_q    <= 1'b0;
            tmo_q        <= 32'd0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkt_begin_q  <= pkt_begin_d;
            pkt_end_q    <= pkt_end_d;
            wr_ptr_q     <= wr_ptr_d;
            seq_q        <= seq_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            err_q        <= err_d;
            gap_q        <= gap_d;
            wrap_q       <= wrap_d;
            addr_q       <= addr_d;
            wr_ctrl_q    <= wr_ctrl_d;
            tmo_q        <= tmo_d;
            enable_q     <= enable;
        end
    end

    assign wr_ctrl       = wr_ctrl_q;
    assign control       = {seq_q, 15'b0, wrap_q};
    assign pkt_begin     = pkt_begin_q;
    assign pkt_end       = pkt_end_q;
    assign write_address = addr_q;
    assign wr_ptr        = wr_ptr_q;
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;
    assign busy          = (state_q != StIdle);
    assign err           = err_q;

endmodule

// File: tb/tb_capture_ring_sched.sv
// Bench for capture_ring_sched: transaction-level ring model driven alongside the DUT, checked
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_capture_ring_sched;

    localparam int unsigned TMO  = 100;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] RING = 32'h0000_4000;
    localparam logic [31:0] MAXP = 32'd2048;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] ring_base;
    logic [31:0] ring_size;
    logic [31:0] host_rd_ptr;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_begin;
    logic [31:0] desc_end;
    logic        wr_ctrl;
    logic [31:0] control;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic [31:0] write_address;
    logic        wr_ctrl_rdy;
    logic [31:0] wr_ptr;
    logic [31:0] pkt_count;
    logic [15:0] drop_count;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    capture_ring_sched #(
        .HDR_BYTES      (16),
        .MAX_PKT        (2048),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .ring_base     (ring_base),
        .ring_size     (ring_size),
        .host_rd_ptr   (host_rd_ptr),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_begin    (desc_begin),
        .desc_end      (desc_end),
        .wr_ctrl       (wr_ctrl),
        .control       (control),
        .pkt_begin     (pkt_begin),
        .pkt_end       (pkt_end),
        .write_address (write_address),
        .wr_ctrl_rdy   (wr_ctrl_rdy),
        .wr_ptr        (wr_ptr),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count),
        .busy          (busy),
        .err           (err)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Model state, updated by the driver just after the edge at which the DUT should change.
    logic [31:0] m_wr_ptr, m_cnt;
    logic [15:0] m_seq, m_drop;
    logic        m_err, m_busy, m_wrc, m_hold, chk_en;
    logic [31:0] e_addr, e_ctrl, e_begin, e_end;
    logic [31:0] cap_addr, cap_ctrl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_ctrl", {31'b0, wr_ctrl}, {31'b0, m_wrc});
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("err", {31'b0, err}, {31'b0, m_err});
            check("desc_ready", {31'b0, desc_ready}, {31'b0, (!m_busy && enable && !m_err)});
            check("wr_ptr", wr_ptr, m_wr_ptr);
            check("pkt_count", pkt_count, m_cnt);
            check("drop_count", {16'b0, drop_count}, {16'b0, m_drop});
            if (m_hold) begin
                check("write_address", write_address, e_addr);
                check("control", control, e_ctrl);
                check("pkt_begin", pkt_begin, e_begin);
                check("pkt_end", pkt_end, e_end);
            end
        end
    end

    function automatic bit fits(input logic [31:0] wp, input logic [31:0] rd,
                                input logic [31:0] gap, input logic [31:0] rec);
        logic [63:0] occ, fr;
        occ = ({32'b0, wp} + {32'b0, RING} - {32'b0, rd}) % {32'b0, RING};
        fr  = {32'b0, RING} - occ;
        return ({32'b0, gap} + {32'b0, rec}) < fr;
    endfunction

    task automatic model_clear();
        m_wr_ptr = 0; m_cnt = 0; m_seq = 0; m_drop = 0;
        m_err = 0; m_busy = 0; m_wrc = 0; m_hold = 0;
    endtask

    // One descriptor end to end. ack_dly < 0 withholds completion until the timeout fires;
    // abort_en drops enable after stall_max stalled cycles instead of releasing host_rd_ptr.
    task automatic send(input logic [31:0] b, input logic [31:0] len, input int ack_dly,
                        input int stall_max, input logic [31:0] rel_rd, input bit abort_en);
        logic [31:0] rec, room, gap, off, nxt;
        int waited;
        desc_begin = b;
        desc_end   = b + len;
        desc_valid = 1'b1;
        @(posedge clk); #1;
        desc_valid = 1'b0;
        m_busy  = 1'b1;
        e_begin = b;
        e_end   = b + len;
        if (len == 0 || len > MAXP) begin
            @(posedge clk); #1;
            if (m_drop != 16'hFFFF) m_drop++;
            m_busy = 1'b0;
            return;
        end
        rec  = 32'd16 + 32'd4 * ((len + 32'd3) / 32'd4);
        room = RING - m_wr_ptr;
        gap  = (room < rec) ? room : 32'd0;
        waited = 0;
        while (!fits(m_wr_ptr, host_rd_ptr, gap, rec)) begin
            if (waited == stall_max) begin
                if (abort_en) begin
                    enable = 1'b0;
                    @(posedge clk); #1;
                    if (m_drop != 16'hFFFF) m_drop++;
                    m_busy = 1'b0;
                    return;
                end
                host_rd_ptr = rel_rd;
            end
            if (!fits(m_wr_ptr, host_rd_ptr, gap, rec)) begin
                if (waited > 500) begin
                    $display("FAIL stall_bound: got %0d stalled cycles, expected at most 500",
                             waited);
                    $fatal(1);
                end
                @(posedge clk); #1;
                waited++;
            end
        end
        off    = (gap != 0) ? 32'd0 : m_wr_ptr;
        e_addr = BASE + off;
        e_ctrl = {m_seq, 15'b0, (gap != 0)};
        @(posedge clk); #1;
        m_wrc    = 1'b1;
        m_hold   = 1'b1;
        cap_addr = write_address;
        cap_ctrl = control;
        @(posedge clk); #1;
        m_wrc = 1'b0;
        if (ack_dly < 0) begin
            repeat (TMO) @(posedge clk);
            #1;
            m_err  = 1'b1;
            m_hold = 1'b0;
            return;
        end
        repeat (ack_dly) begin
            @(posedge clk); #1;
        end
        wr_ctrl_rdy = 1'b1;
        @(posedge clk); #1;
        wr_ctrl_rdy = 1'b0;
        nxt      = off + rec;
        m_wr_ptr = (nxt == RING) ? 32'd0 : nxt;
        m_seq++;
        m_cnt++;
        m_busy = 1'b0;
        m_hold = 1'b0;
    endtask

    task automatic advance_to(input logic [31:0] target);
        logic [31:0] rem, rec;
        while (m_wr_ptr != target) begin
            rem = target - m_wr_ptr;
            rec = (rem >= 32'd2084) ? 32'd2064 : rem;
            host_rd_ptr = m_wr_ptr;
            send(32'h0, rec - 32'd16, 1, 0, m_wr_ptr, 1'b0);
        end
    endtask

    task automatic stray_ack();
        wr_ctrl_rdy = 1'b1;
        @(posedge clk); #1;
        wr_ctrl_rdy = 1'b0;
    endtask

    task automatic enable_cycle();
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        m_wr_ptr = 0;
        m_seq    = 0;
    endtask

    task automatic do_reset();
        chk_en      = 1'b0;
        enable      = 1'b0;
        desc_valid  = 1'b0;
        wr_ctrl_rdy = 1'b0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check("rst_wr_ptr", wr_ptr, 32'h0);
        check("rst_pkt_count", pkt_count, 32'h0);
        check("rst_drop_count", {16'b0, drop_count}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_wr_ctrl", {31'b0, wr_ctrl}, 32'h0);
        check("rst_desc_ready", {31'b0, desc_ready}, 32'h0);
        check("rst_control", control, 32'h0);
        check("rst_write_address", write_address, 32'h0);
        check("rst_pkt_begin", pkt_begin, 32'h0);
        check("rst_pkt_end", pkt_end, 32'h0);
        chk_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] len, b;
        int sel;
        ring_base   = BASE;
        ring_size   = RING;
        host_rd_ptr = 32'h0;
        desc_begin  = 32'h0;
        desc_end    = 32'h0;
        e_addr = 0; e_ctrl = 0; e_begin = 0; e_end = 0;
        model_clear();
        do_reset();
        enable = 1'b1;
        @(posedge clk); #1;

        send(32'h0, 32'h40, 3, 0, 32'h0, 1'b0);
        check("basic_addr", cap_addr, 32'h1000_0000);
        check("basic_ctrl", cap_ctrl, 32'h0000_0000);
        check("basic_wr_ptr", wr_ptr, 32'h50);
        check("basic_pkt_count", pkt_count, 32'h1);

        send(32'h1000, 32'd61, 2, 0, 32'h0, 1'b0);
        check("round_addr", cap_addr, 32'h1000_0050);
        check("round_ctrl", cap_ctrl, 32'h0001_0000);
        check("round_wr_ptr", wr_ptr, 32'hA0);

        advance_to(32'h3FC0);
        check("pre_wrap_wr_ptr", wr_ptr, 32'h3FC0);
        host_rd_ptr = 32'h2000;
        send(32'h200, 32'd100, 4, 0, 32'h2000, 1'b0);
        check("wrap_addr", cap_addr, 32'h1000_0000);
        check("wrap_ctrl", cap_ctrl, 32'h000A_0001);
        check("wrap_wr_ptr", wr_ptr, 32'h74);

        enable_cycle();
        check("rerise_wr_ptr", wr_ptr, 32'h0);

        advance_to(32'h3F00);
        host_rd_ptr = 32'h3F40;
        send(32'h300, 32'd64, 2, 4, 32'h0, 1'b0);
        check("stall_addr", cap_addr, 32'h1000_3F00);
        check("stall_ctrl", cap_ctrl, 32'h0008_0000);
        check("stall_wr_ptr", wr_ptr, 32'h3F50);

        send(32'h100, 32'd0, 0, 0, 32'h0, 1'b0);
        send(32'h100, 32'd4000, 0, 0, 32'h0, 1'b0);
        check("illegal_drops", {16'b0, drop_count}, 32'h2);
        check("illegal_ready", {31'b0, desc_ready}, 32'h1);
        check("illegal_pkt_count", pkt_count, 32'd20);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) stray_ack();
            host_rd_ptr = ($urandom_range(0, 1) == 0) ? m_wr_ptr
                                                      : 32'($urandom_range(0, 1023)) * 32'd16;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 32'd0 : (MAXP + 32'($urandom_range(1, 9999)));
            end else begin
                len = 32'($urandom_range(1, 2048));
            end
            b = $urandom;
            send(b, len, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), m_wr_ptr, 1'b0);
        end

        host_rd_ptr = (m_wr_ptr + 32'd16) % RING;
        send(32'h40, 32'd64, 0, 2, 32'h0, 1'b1);
        check("abort_busy", {31'b0, busy}, 32'h0);
        enable = 1'b1;
        @(posedge clk); #1;
        m_wr_ptr = 0;
        m_seq    = 0;

        host_rd_ptr = 32'h0;
        send(32'h0, 32'd64, -1, 0, 32'h0, 1'b0);
        check("tmo_err", {31'b0, err}, 32'h1);
        check("tmo_ready", {31'b0, desc_ready}, 32'h0);
        stray_ack();
        check("tmo_late_ack_err", {31'b0, err}, 32'h1);

        do_reset();
        enable = 1'b1;
        @(posedge clk); #1;
        send(32'h0, 32'h40, 2, 0, 32'h0, 1'b0);
        check("post_rst_addr", cap_addr, 32'h1000_0000);
        check("post_rst_ctrl", cap_ctrl, 32'h0000_0000);
        check("post_rst_wr_ptr", wr_ptr, 32'h50);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
